mul_share_arbiter: RTL and testbench

- Round-robin scheduler that shares one external 4x4 combinational multiplier (WallaceTreeMult) between two requesters.
- Accepts operands from the granted requester and drives them onto the multiplier inputs.
- Waits a fixed settle time, captures the product, and returns it with a one-cycle done pulse.
- Sits between requesting datapath blocks and the single multiplier instance.

---
 rtl/mul_share_arbiter.sv | 131 +++++++++++++
 tb/tb_mul_share_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one external 4x4
// multiplier between two requesters, with a fixed settle time.
module mul_share_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] p_out,
    output logic       busy,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic [7:0] mul_p
);

    localparam int CW = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          done0_q, done0_d;
    logic          done1_q, done1_d;
    logic [7:0]    p_q, p_d;
    logic [3:0]    ma_q, ma_d;
    logic [3:0]    mb_q, mb_d;
    logic          any_req;
    logic          pick1;

    // Sole requester wins; on a tie the one not served last wins
    always_comb begin
        any_req = req0 | req1;
        pick1   = req1 & (~req0 | ~last_q);
    end

    // Next state and next values of every registered output
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        done0_d = 1'b0;
        done1_d = 1'b0;
        p_d     = p_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick1;
                    last_d  = pick1;
                    gnt0_d  = ~pick1;
                    gnt1_d  = pick1;
                    ma_d    = pick1 ? a1 : a0;
                    mb_d    = pick1 ? b1 : b0;
                    cnt_d   = CNT_LOAD;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    p_d     = mul_p;
                    done0_d = ~owner_q;
                    done1_d = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any operation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            p_q     <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
            p_q     <= p_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
        end
    end

    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign done0 = done0_q;
    assign done1 = done1_q;
    assign p_out = p_q;
    assign mul_a = ma_q;
    assign mul_b = mb_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb_mul_share_arbiter: table vectors, corner sequences and random
// traffic checked against an event-schedule reference model.
module tb_mul_share_arbiter;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic [3:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic       gnt0, gnt1, done0, done1, busy;
    logic [7:0] p_out, mul_p;
    logic [3:0] mul_a, mul_b;

    logic       s_req0 = 1'b0;
    logic [3:0] s_a0 = '0, s_b0 = '0;
    logic       s_gnt0, s_gnt1, s_done0, s_done1, s_busy;
    logic [7:0] s_p_out, s_mul_p;
    logic [3:0] s_mul_a, s_mul_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Behavioural stand-ins for the shared multiplier
    assign mul_p   = {4'b0, mul_a} * {4'b0, mul_b};
    assign s_mul_p = {4'b0, s_mul_a} * {4'b0, s_mul_b};

    mul_share_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .p_out(p_out), .busy(busy),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
    );

    mul_share_arbiter #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .req0(s_req0), .a0(s_a0), .b0(s_b0),
        .req1(1'b0), .a1(4'd0), .b1(4'd0),
        .gnt0(s_gnt0), .gnt1(s_gnt1),
        .done0(s_done0), .done1(s_done1),
        .p_out(s_p_out), .busy(s_busy),
        .mul_a(s_mul_a), .mul_b(s_mul_b), .mul_p(s_mul_p)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic int at(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // Reference model: schedules grant/done by edge number
    int         m_cyc, m_free, m_done_at, m_prod;
    logic       m_last, m_owner, win;
    logic       e_gnt0, e_gnt1, e_done0, e_done1, e_busy;
    logic [7:0] e_p;
    logic [3:0] e_ma, e_mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = 0; m_free = 0; m_done_at = -1; m_prod = 0;
            m_last = 1'b1; m_owner = 1'b0;
            e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
            e_busy = 0; e_p = '0; e_ma = '0; e_mb = '0;
        end else begin
            m_cyc++;
            e_gnt0 = 0; e_gnt1 = 0; e_done0 = 0; e_done1 = 0;
            if (m_cyc == m_done_at) begin
                if (m_owner) e_done1 = 1'b1;
                else         e_done0 = 1'b1;
                e_p = 8'(m_prod);
            end
            if (m_cyc >= m_free && (req0 || req1)) begin
                win = (req0 && req1) ? !m_last : req1;
                m_owner = win;
                m_last  = win;
                if (win) begin
                    e_gnt1 = 1'b1; e_ma = a1; e_mb = b1;
                    m_prod = int'(a1) * int'(b1);
                end else begin
                    e_gnt0 = 1'b1; e_ma = a0; e_mb = b0;
                    m_prod = int'(a0) * int'(b0);
                end
                m_done_at = m_cyc + W;
                m_free    = m_cyc + W + 1;
            end
            e_busy = (m_cyc < m_done_at);
        end
    end

    // Compare every output with the model each cycle
    always @(negedge clk) begin
        if (!rst) begin
            chk("m_gnt0", gnt0, e_gnt0);
            chk("m_gnt1", gnt1, e_gnt1);
            chk("m_done0", done0, e_done0);
            chk("m_done1", done1, e_done1);
            chk("m_busy", busy, e_busy);
            chk("m_p_out", p_out, e_p);
            chk("m_mul_a", mul_a, e_ma);
            chk("m_mul_b", mul_b, e_mb);
        end
    end

    logic [3:0] qa0[$], qb0[$], qa1[$], qb1[$];
    int g_port[$], g_time[$], d_port[$], d_time[$], d_p[$];

    task automatic run_seq(input int n_done, input int bound);
        g_port.delete(); g_time.delete();
        d_port.delete(); d_time.delete(); d_p.delete();
        @(negedge clk);
        if (qa0.size() > 0) begin
            req0 = 1; a0 = qa0.pop_front(); b0 = qb0.pop_front();
        end
        if (qa1.size() > 0) begin
            req1 = 1; a1 = qa1.pop_front(); b1 = qb1.pop_front();
        end
        for (int t = 1; t <= bound && d_port.size() < n_done; t++) begin
            @(negedge clk);
            if (gnt0) begin
                g_port.push_back(0); g_time.push_back(t);
                if (qa0.size() > 0) begin
                    a0 = qa0.pop_front(); b0 = qb0.pop_front();
                end else req0 = 0;
            end
            if (gnt1) begin
                g_port.push_back(1); g_time.push_back(t);
                if (qa1.size() > 0) begin
                    a1 = qa1.pop_front(); b1 = qb1.pop_front();
                end else req1 = 0;
            end
            if (done0) begin
                d_port.push_back(0); d_time.push_back(t);
                d_p.push_back(int'(p_out));
            end
            if (done1) begin
                d_port.push_back(1); d_time.push_back(t);
                d_p.push_back(int'(p_out));
            end
        end
        req0 = 0; req1 = 0;
        chk("seq_done_count", d_port.size(), n_done);
    endtask

    typedef struct {
        int         port;
        logic [3:0] a;
        logic [3:0] b;
        int         exp_p;
    } vec_t;

    vec_t tbl[6];
    int   sg[$], sd[$];
    int   exp_ord[4];
    int   exp_p4[4];

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 4'd11, 4'd10, 110};
        tbl[1] = '{1, 4'd8,  4'd0,  0};
        tbl[2] = '{0, 4'd15, 4'd15, 225};
        tbl[3] = '{1, 4'd15, 4'd15, 225};
        tbl[4] = '{1, 4'd1,  4'd1,  1};
        tbl[5] = '{0, 4'd0,  4'd7,  0};

        repeat (3) @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_done0", done0, 0);
        chk("rst_done1", done1, 0);
        chk("rst_p_out", p_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mul_a", mul_a, 0);
        chk("rst_mul_b", mul_b, 0);
        rst = 0;

        // Single operations from the vector table
        foreach (tbl[i]) begin
            if (tbl[i].port == 0) begin
                qa0.push_back(tbl[i].a); qb0.push_back(tbl[i].b);
            end else begin
                qa1.push_back(tbl[i].a); qb1.push_back(tbl[i].b);
            end
            run_seq(1, 12);
            chk("tbl_gnt_port", at(g_port, 0), tbl[i].port);
            chk("tbl_gnt_lat", at(g_time, 0), 1);
            chk("tbl_done_lat", at(d_time, 0) - at(g_time, 0), W);
            chk("tbl_done_port", at(d_port, 0), tbl[i].port);
            chk("tbl_p", at(d_p, 0), tbl[i].exp_p);
            @(negedge clk);
            chk("tbl_p_hold", p_out, tbl[i].exp_p);
        end

        // First tie after reset goes to requester 0
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        qa0.push_back(15); qb0.push_back(15);
        qa1.push_back(10); qb1.push_back(14);
        run_seq(2, 20);
        chk("tie_first", at(g_port, 0), 0);
        chk("tie_p0", at(d_p, 0), 225);
        chk("tie_dport0", at(d_port, 0), 0);
        chk("tie_gnt1_after", at(g_time, 1) - at(d_time, 0), 1);
        chk("tie_second", at(g_port, 1), 1);
        chk("tie_p1", at(d_p, 1), 140);

        // Both held with fresh operands: strict alternation
        qa0 = '{4'd9, 4'd2}; qb0 = '{4'd8, 4'd14};
        qa1 = '{4'd1, 4'd3}; qb1 = '{4'd12, 4'd11};
        exp_ord = '{0, 1, 0, 1};
        exp_p4  = '{72, 12, 28, 33};
        run_seq(4, 40);
        for (int i = 0; i < 4; i++) begin
            chk("alt_gnt_port", at(g_port, i), exp_ord[i]);
            chk("alt_p", at(d_p, i), exp_p4[i]);
        end
        chk("alt_period", at(g_time, 3) - at(g_time, 2), W + 1);

        // Reset during CALC aborts the operation
        @(negedge clk);
        req0 = 1; a0 = 7; b0 = 9;
        @(negedge clk);
        chk("abort_gnt0", gnt0, 1);
        req0 = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("abort_p_out", p_out, 0);
        chk("abort_mul_a", mul_a, 0);
        chk("abort_mul_b", mul_b, 0);
        chk("abort_busy", busy, 0);
        @(negedge clk);
        chk("abort_no_done", done0, 0);
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_quiet", done0, 0);
        end
        qa0.push_back(7); qb0.push_back(9);
        qa1.push_back(3); qb1.push_back(3);
        run_seq(2, 20);
        chk("abort_tie_first", at(g_port, 0), 0);
        chk("abort_tie_p", at(d_p, 0), 63);
        chk("abort_tie_p1", at(d_p, 1), 9);

        // Random traffic with the req/gnt handshake
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            if (gnt0) req0 = 0;
            if (gnt1) req1 = 0;
            if (!req0) begin
                a0 = 4'($urandom); b0 = 4'($urandom);
                if ($urandom_range(0, 2) == 0) req0 = 1;
            end
            if (!req1) begin
                a1 = 4'($urandom); b1 = 4'($urandom);
                if ($urandom_range(0, 2) == 0) req1 = 1;
            end
        end
        req0 = 0; req1 = 0;
        repeat (6) @(negedge clk);

        // WAIT_CYCLES=1 instance, request held continuously
        s_a0 = 5; s_b0 = 3; s_req0 = 1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (s_gnt0) sg.push_back(t);
            if (s_done0) begin
                sd.push_back(t);
                chk("w1_p", s_p_out, 15);
            end
            chk("w1_no_gnt1", s_gnt1, 0);
        end
        s_req0 = 0;
        chk("w1_first_gnt", at(sg, 0), 1);
        for (int i = 0; i < 3; i++) begin
            chk("w1_period", at(sg, i + 1) - at(sg, i), 2);
            chk("w1_done_lat", at(sd, i) - at(sg, i), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
